// File: rtl/prog_loader_if.sv
// Byte-serial loader bus: host byte link in, instruction-memory load port and status out.
// Combinational wiring only; no latency of its own.
// Backpressure is the byte_valid/byte_ready pair; the load port has no backpressure.
interface prog_loader_if;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        load_en;
   logic [31:0] load_inst;
   logic [7:0]  word_count;
   logic        busy;
   logic        done;
   logic        timeout_err;
   logic        checksum_err;

   // Host / testbench side: offers bytes and observes the load port.
   modport master (
      output start, byte_valid, byte_data,
      input  byte_ready, load_en, load_inst, word_count, busy, done, timeout_err, checksum_err
   );

   // Loader side.
   modport slave (
      input  start, byte_valid, byte_data,
      output byte_ready, load_en, load_inst, word_count, busy, done, timeout_err, checksum_err
   );
endinterface

// File: rtl/prog_loader.sv
// Program loader: packs a little-endian byte stream into 32-bit words and strobes them into imem.
// Latency: load_en one cycle after the 4th byte of a word; peak rate 4 bytes per 5 cycles.
// Backpressure: byte_ready drops during WRITE, IDLE and DONE; an idle gap of TIMEOUT_CYCLES aborts.
// Optional macro PROG_LOADER_CHECKSUM_EN adds a CHECK state that compares a trailing 32-bit sum.
module prog_loader #(
   parameter int NUM_WORDS      = 256,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic          clk,
   input  logic          rst_n,
   prog_loader_if.slave  ld_if
);

   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;

   state_t         state_q;
   logic [1:0]     idx_q;
   logic [23:0]    shreg_q;
   logic [GW-1:0]  gap_q;
   logic           byte_ready_q;
   logic           load_en_q;
   logic [31:0]    load_inst_q;
   logic [7:0]     word_count_q;
   logic           busy_q;
   logic           done_q;
   logic           timeout_err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [31:0]    sum_q;
   logic           checksum_err_q;
`endif

   logic           accept_d;
   logic [31:0]    word_d;
   logic           last_word_d;
   logic           gap_hit_d;

   // Handshake, the word completed by the current byte, and the end/timeout conditions.
   always_comb begin
      accept_d    = ld_if.byte_valid & byte_ready_q;
      word_d      = {ld_if.byte_data, shreg_q};
      last_word_d = (({1'b0, word_count_q} + 9'd1) == 9'(NUM_WORDS));
      gap_hit_d   = (gap_q == GW'(TIMEOUT_CYCLES - 1));
   end

   // Load FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         shreg_q        <= '0;
         gap_q          <= '0;
         byte_ready_q   <= 1'b0;
         load_en_q      <= 1'b0;
         load_inst_q    <= '0;
         word_count_q   <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         timeout_err_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q          <= '0;
         checksum_err_q <= 1'b0;
`endif
      end else begin
         load_en_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (ld_if.start) begin
                  state_q        <= S_RECV;
                  word_count_q   <= '0;
                  idx_q          <= '0;
                  gap_q          <= '0;
                  timeout_err_q  <= 1'b0;
                  byte_ready_q   <= 1'b1;
                  busy_q         <= 1'b1;
                  done_q         <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                  sum_q          <= '0;
                  checksum_err_q <= 1'b0;
`endif
               end
            end

`ifdef PROG_LOADER_CHECKSUM_EN
            S_RECV, S_CHECK: begin
`else
            S_RECV: begin
`endif
               if (accept_d) begin
                  gap_q <= '0;
                  if (idx_q == 2'd3) begin
                     idx_q        <= '0;
                     byte_ready_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                     if (state_q == S_CHECK) begin
                        // Trailing checksum word: compare only, never written to imem.
                        if (word_d != sum_q) checksum_err_q <= 1'b1;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        load_inst_q <= word_d;
                        load_en_q   <= 1'b1;
                        state_q     <= S_WRITE;
                     end
`else
                     load_inst_q <= word_d;
                     load_en_q   <= 1'b1;
                     state_q     <= S_WRITE;
`endif
                  end else begin
                     shreg_q[{idx_q, 3'b000} +: 8] <= ld_if.byte_data;
                     idx_q <= idx_q + 2'd1;
                  end
               end else if (gap_hit_d) begin
                  // Abort on a stalled link; words already written stay written.
                  timeout_err_q <= 1'b1;
                  state_q       <= S_IDLE;
                  byte_ready_q  <= 1'b0;
                  busy_q        <= 1'b0;
                  idx_q         <= '0;
                  gap_q         <= '0;
               end else begin
                  gap_q <= gap_q + GW'(1);
               end
            end

            S_WRITE: begin
               word_count_q <= word_count_q + 8'd1;
               gap_q        <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_q        <= sum_q + load_inst_q;
`endif
               if (last_word_d) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  state_q      <= S_CHECK;
                  byte_ready_q <= 1'b1;
`else
                  state_q      <= S_DONE;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
`endif
               end else begin
                  state_q      <= S_RECV;
                  byte_ready_q <= 1'b1;
               end
            end

            default: begin
               state_q      <= S_IDLE;
               byte_ready_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign ld_if.byte_ready   = byte_ready_q;
   assign ld_if.load_en      = load_en_q;
   assign ld_if.load_inst    = load_inst_q;
   assign ld_if.word_count   = word_count_q;
   assign ld_if.busy         = busy_q;
   assign ld_if.done         = done_q;
   assign ld_if.timeout_err  = timeout_err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
   assign ld_if.checksum_err = checksum_err_q;
`else
   assign ld_if.checksum_err = 1'b0;
`endif

endmodule
